// File: rtl/ext_bus_arb.sv
// Two-master round-robin arbiter and sequencer for the external 16-bit data bus.
// One transaction in flight; strobes are held until s_ack or a bounded timeout.
module ext_bus_arb #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_done,
  output logic        m0_err,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [15:0] m1_rdata,
  output logic        s_re,
  output logic        s_we,
  output logic [15:0] s_addr,
  output logic [15:0] s_wdata,
  input  logic [15:0] s_rdata,
  input  logic        s_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        s_re_q, s_re_d, s_we_q, s_we_d;
  logic [15:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic        m0_done_q, m0_done_d, m0_err_q, m0_err_d;
  logic [15:0] m0_rdata_q, m0_rdata_d;
  logic        m1_done_q, m1_done_d, m1_err_q, m1_err_d;
  logic [15:0] m1_rdata_q, m1_rdata_d;

  logic        pick;
  logic        sel_we;
  logic [15:0] sel_addr, sel_wdata;
  logic        fin, fin_err;
  logic [15:0] fin_rdata;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    s_re_d     = s_re_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    m0_done_d  = 1'b0;
    m0_err_d   = 1'b0;
    m0_rdata_d = 16'h0000;
    m1_done_d  = 1'b0;
    m1_err_d   = 1'b0;
    m1_rdata_d = 16'h0000;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_rdata  = 16'h0000;
    // pick=1 selects master 1; on a tie the master not granted last wins
    pick       = (m0_req && m1_req) ? ~last_q : m1_req;
    sel_we     = pick ? m1_we    : m0_we;
    sel_addr   = pick ? m1_addr  : m0_addr;
    sel_wdata  = pick ? m1_wdata : m0_wdata;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          last_d    = pick;
          cnt_d     = 8'd0;
          s_addr_d  = sel_addr;
          s_wdata_d = sel_wdata;
          if (sel_addr[15:13] == 3'b000) begin
            // Internal DM range: never reaches the external slave
            state_d   = DONE;
            fin       = 1'b1;
            fin_err   = 1'b1;
            fin_rdata = ERR_DATA;
          end else begin
            state_d = BUSY;
            s_re_d  = ~sel_we;
            s_we_d  = sel_we;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (s_ack) begin
          state_d   = DONE;
          s_re_d    = 1'b0;
          s_we_d    = 1'b0;
          fin       = 1'b1;
          fin_rdata = s_we_q ? 16'h0000 : s_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          s_re_d    = 1'b0;
          s_we_d    = 1'b0;
          fin       = 1'b1;
          fin_err   = 1'b1;
          fin_rdata = ERR_DATA;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The completion response goes only to the master that owns the bus
    if (fin) begin
      if (last_d) begin
        m1_done_d  = 1'b1;
        m1_err_d   = fin_err;
        m1_rdata_d = fin_rdata;
      end else begin
        m0_done_d  = 1'b1;
        m0_err_d   = fin_err;
        m0_rdata_d = fin_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      cnt_q      <= 8'd0;
      s_re_q     <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= 16'h0000;
      s_wdata_q  <= 16'h0000;
      m0_done_q  <= 1'b0;
      m0_err_q   <= 1'b0;
      m0_rdata_q <= 16'h0000;
      m1_done_q  <= 1'b0;
      m1_err_q   <= 1'b0;
      m1_rdata_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      s_re_q     <= s_re_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      m0_done_q  <= m0_done_d;
      m0_err_q   <= m0_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_done_q  <= m1_done_d;
      m1_err_q   <= m1_err_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign s_re     = s_re_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign m0_done  = m0_done_q;
  assign m0_err   = m0_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_done  = m1_done_q;
  assign m1_err   = m1_err_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_ext_bus_arb.sv
// Randomized bench for ext_bus_arb: a transaction-level model predicts grant order,
// completion cycle and response; a slave model and a done monitor check the DUT.
module tb_ext_bus_arb;

  localparam int          TIMEOUT  = 15;
  localparam logic [15:0] ERR_DATA = 16'hFFFF;
  localparam int          EW       = 50;

  // Handshake: a master holds req until its done pulse; done/err/rdata are valid
  // together for one cycle; the slave holds s_ack for exactly one strobe cycle.

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [15:0] m0_rdata, m1_rdata;
  logic        s_re, s_we, s_ack;
  logic [15:0] s_addr, s_wdata, s_rdata;

  ext_bus_arb #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_re(s_re), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          ack_at;
    logic [15:0] data;
  } plan_t;

  // exp_q entry: {master, err, rdata, done cycle}
  logic [EW-1:0] exp_q[$];
  plan_t         slave_q[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic last_m = 1'b1;
  logic rst_abort = 1'b0;

  logic        t_use[2], t_we[2];
  logic [15:0] t_addr[2], t_wdata[2], t_data[2];
  int          t_ack[2];
  logic        t_mess;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int m, input logic rq, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (m == 0) begin
      m0_req = rq; m0_we = w; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = rq; m1_we = w; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic clear_round();
    for (int m = 0; m < 2; m++) begin
      t_use[m] = 1'b0; t_we[m] = 1'b0; t_addr[m] = 16'h0; t_wdata[m] = 16'h0;
      t_ack[m] = 1; t_data[m] = 16'h0;
    end
    t_mess = 1'b0;
  endtask

  task automatic setup(input int m, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input int k, input logic [15:0] r);
    t_use[m] = 1'b1; t_we[m] = w; t_addr[m] = a; t_wdata[m] = d; t_ack[m] = k; t_data[m] = r;
  endtask

  // Reference model: grant order from round-robin, then completion timing from
  // 2 + wait cycles (1 for a decode reject) and a one-cycle IDLE gap between grants.
  task automatic run_round();
    int          g[2];
    int          order[2];
    int          nord, t, m, kef, dc;
    logic        err;
    logic [15:0] rd;
    logic [1:0]  pend;
    plan_t       p;
    g[0] = -10; g[1] = -10;
    @(negedge clk);
    t = cyc;
    nord = (t_use[0] && t_use[1]) ? 2 : 1;
    if (nord == 2) order[0] = last_m ? 0 : 1;
    else           order[0] = t_use[1] ? 1 : 0;
    order[1] = 1 - order[0];
    for (int i = 0; i < nord; i++) begin
      m = order[i];
      g[m] = t;
      if (t_addr[m][15:13] == 3'b000) begin
        dc = t + 1; err = 1'b1; rd = ERR_DATA;
      end else begin
        kef = (t_ack[m] == 0) ? TIMEOUT : t_ack[m];
        dc  = t + 1 + kef;
        err = (t_ack[m] == 0);
        rd  = err ? ERR_DATA : (t_we[m] ? 16'h0000 : t_data[m]);
        p.addr = t_addr[m]; p.we = t_we[m]; p.wdata = t_wdata[m];
        p.ack_at = t_ack[m]; p.data = t_data[m];
        slave_q.push_back(p);
      end
      exp_q.push_back({1'(m), err, rd, 32'(dc)});
      last_m = 1'(m);
      t = dc + 1;
    end
    for (int i = 0; i < 2; i++)
      if (t_use[i]) drive(i, 1'b1, t_we[i], t_addr[i], t_wdata[i]);
    pend = {t_use[1], t_use[0]};
    for (int i = 0; i < 80 && pend != 2'b00; i++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (pend[j]) begin
          if ((j == 0 && m0_done) || (j == 1 && m1_done)) begin
            pend[j] = 1'b0;
            drive(j, 1'b0, 1'b0, 16'h0, 16'h0);
          end else if (t_mess && cyc == g[j] + 1) begin
            // After grant: request fields and req itself must no longer matter
            drive(j, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
          end
        end
      end
    end
    if (pend != 2'b00) begin
      chk("round_done_timeout", 80'(pend), 80'(0));
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    end
  endtask

  // ---------------- slave model ----------------
  initial begin
    plan_t p;
    int    n;
    logic  stable_ok;
    s_ack = 1'b0;
    s_rdata = 16'h0;
    forever begin
      @(negedge clk);
      s_ack = 1'b0;
      if (s_re || s_we) begin
        if (slave_q.size() == 0) begin
          chk("unexpected_strobe", 80'({s_re, s_we}), 80'(0));
        end else begin
          p = slave_q.pop_front();
          stable_ok = 1'b1;
          n = 0;
          while (n < TIMEOUT + 2) begin
            n++;
            if (s_addr !== p.addr || s_wdata !== p.wdata || s_we !== p.we || s_re !== ~p.we)
              stable_ok = 1'b0;
            s_ack   = (n == p.ack_at);
            s_rdata = (n == p.ack_at) ? p.data : 16'($urandom);
            @(negedge clk);
            s_ack = 1'b0;
            if (!(s_re || s_we)) break;
          end
          if (!rst_abort) begin
            chk("strobe_fields", 80'(stable_ok), 80'(1));
            chk("strobe_cycles", 80'(n), 80'((p.ack_at == 0) ? TIMEOUT : p.ack_at));
          end
        end
      end else begin
        // Stray acks outside a transaction must be ignored
        s_ack   = ($urandom_range(0, 5) == 0);
        s_rdata = 16'($urandom);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic          gm;
    if (!rst && (m0_done || m1_done)) begin
      gm = m1_done;
      chk("done_exclusive", 80'(m0_done & m1_done), 80'(0));
      chk("no_strobe_in_done", 80'({s_re, s_we}), 80'(0));
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 80'({m0_done, m1_done}), 80'(0));
      end else begin
        e = exp_q.pop_front();
        chk("done_master", 80'(gm), 80'(e[49]));
        chk("done_err", 80'(gm ? m1_err : m0_err), 80'(e[48]));
        chk("done_rdata", 80'(gm ? m1_rdata : m0_rdata), 80'(e[47:32]));
        chk("done_cycle", 80'(cyc), 80'(e[31:0]));
        chk("other_master_quiet", gm ? 80'({m0_done, m0_err, m0_rdata}) : 80'({m1_done, m1_err, m1_rdata}), 80'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    clear_round();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 80'({m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata, s_re, s_we, s_addr, s_wdata}), 80'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    clear_round(); setup(0, 1'b1, 16'h2004, 16'hBEEF, 1, 16'h0);  run_round();
    clear_round(); setup(1, 1'b0, 16'hC000, 16'h0000, 3, 16'h1234); run_round();
    repeat (2) begin
      clear_round();
      setup(0, 1'b1, 16'h4010, 16'h1111, 1, 16'h0);
      setup(1, 1'b0, 16'hE020, 16'h0000, 1, 16'h5A5A);
      run_round();
    end
    clear_round(); setup(0, 1'b0, 16'h8000, 16'h0, 0, 16'h7777);       run_round();
    clear_round(); setup(0, 1'b0, 16'h8002, 16'h0, TIMEOUT, 16'h3C3C); run_round();
    clear_round(); setup(0, 1'b0, 16'h1FFF, 16'h0, 1, 16'h0);          run_round();

    // Asynchronous reset in the middle of a BUSY transaction
    @(negedge clk);
    begin
      plan_t p;
      p.addr = 16'h6000; p.we = 1'b0; p.wdata = 16'h0; p.ack_at = 0; p.data = 16'h0;
      slave_q.push_back(p);
    end
    drive(0, 1'b1, 1'b0, 16'h6000, 16'h0);
    repeat (4) @(negedge clk);
    chk("busy_before_reset", 80'({s_re, s_we, s_addr}), 80'({1'b1, 1'b0, 16'h6000}));
    @(posedge clk);
    #3;
    rst_abort = 1'b1;
    rst = 1'b1;
    #1;
    chk("reset_async_outputs", 80'({m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata, s_re, s_we, s_addr, s_wdata}), 80'(0));
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    slave_q.delete();
    rst = 1'b0;
    last_m = 1'b1;
    repeat (2) @(negedge clk);
    rst_abort = 1'b0;
    clear_round();
    setup(0, 1'b0, 16'hA000, 16'h0, 2, 16'h0F0F);
    setup(1, 1'b1, 16'hA002, 16'hCAFE, 1, 16'h0);
    run_round();

    for (int i = 0; i < 40; i++) begin
      clear_round();
      r = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++) begin
        if (r[m]) begin
          logic [15:0] a;
          int k;
          a = 16'($urandom);
          if ($urandom_range(0, 3) == 0) a[15:13] = 3'b000;
          else if (a[15:13] == 3'b000) a[15] = 1'b1;
          k = $urandom_range(0, 9);
          if (k == 1) k = TIMEOUT;
          else if (k > 1) k = k - 1;
          setup(m, 1'($urandom_range(0, 1)), a, 16'($urandom), k, 16'($urandom));
        end
      end
      t_mess = 1'($urandom_range(0, 1));
      run_round();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 80'(exp_q.size()), 80'(0));
    chk("slave_q_drained", 80'(slave_q.size()), 80'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_bus_arb.md
# ext_bus_arb

Two-master arbiter and sequencer for the 16-bit external data bus, the path the CPU uses when a load/store address has `addr[15:13] != 0`. It shares one external slave port between master 0 (CPU-side external access shim) and master 1 (DMA/debug engine). It grants round-robin, holds the slave strobes until the slave acknowledges, and aborts a hung access after a bounded number of cycles. One transaction is in flight at a time; no pipelining across masters.

## Interface
- `TIMEOUT`, 15: maximum BUSY cycles waiting for `s_ack` before abort (legal range 1–255).
- `ERR_DATA`, 16'hFFFF: value returned on `mX_rdata` for an aborted or rejected read.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-high.
- `m0_req` input 1: master 0 requests a transaction. Held until `m0_done`.
- `m0_we` input 1: master 0 direction; 1 = write, 0 = read.
- `m0_addr` input 16: master 0 address.
- `m0_wdata` input 16: master 0 write data.
- `m0_done` output 1: one-cycle completion pulse to master 0.
- `m0_err` output 1: valid with `m0_done`; 1 = timeout or address-decode reject.
- `m0_rdata` output 16: master 0 read data, valid with `m0_done`.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_done`, `m1_err`, `m1_rdata`: same as the master 0 ports, for master 1.
- `s_re` output 1: slave read strobe.
- `s_we` output 1: slave write strobe.
- `s_addr` output 16: slave address.
- `s_wdata` output 16: slave write data.
- `s_rdata` input 16: slave read data, sampled in the `s_ack` cycle.
- `s_ack` input 1: slave completion; one cycle.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - If no request is present, stay in IDLE.
  - If only one master requests, grant it.
  - If both request, grant the master not granted last. The round-robin pointer `last` resets to 1, so master 0 wins the first tie.
  - On grant, register the granted master's `we`, `addr` and `wdata` into `s_*`, update `last`, clear the timeout counter, and go to BUSY.
- **Address decode:**
  - If the granted address has `addr[15:13] == 0` (internal DM range), the request is rejected.
  - A rejected request does not drive any strobe. The FSM goes straight to DONE with err=1 and rdata=`ERR_DATA`.
- **BUSY:**
  - `s_re = ~we` and `s_we = we` stay asserted. `s_addr` and `s_wdata` are stable.
  - The counter increments each cycle.
  - On `s_ack`:
    - Capture `s_rdata` for a read; for a write, rdata=0.
    - Set err=0, drop the strobes at the next edge, and go to DONE.
  - If the counter reaches `TIMEOUT` with no ack, drop the strobes, set err=1 and rdata=`ERR_DATA`, and go to DONE.
  - If `s_ack` arrives in the same cycle the counter hits `TIMEOUT`, the ack wins (err=0).
- **DONE:**
  - Assert `mX_done`, `mX_err` and `mX_rdata` for the granted master only. The other master's outputs stay 0.
  - New requests are ignored in this state, which gives the master a cycle to drop `req`.
  - Next state is always IDLE.
- **Mid-transaction changes:**
  - If a master drops `req` during BUSY, the transaction still completes; `done` is still pulsed.
  - Changes to `we`, `addr` or `wdata` after grant are ignored.
- **`s_ack` outside BUSY** is ignored.
- **Reset (asynchronous, at any time):**
  - State returns to IDLE, `last`=1, counter=0.
  - All outputs go to 0: strobes, `s_addr`, `s_wdata`, `mX_done`, `mX_err`, `mX_rdata`.
  - An in-flight transaction is dropped without a `done` pulse.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Zero-wait slave:**
  - Cycle 0: `req` sampled in IDLE.
  - Cycle 1: strobes high; `s_ack` is high in this same cycle.
  - Cycle 2: `done` high.
  - Cycle 3: IDLE, accepting requests.
- **Latency:** request to `done` = 2 + wait cycles. Back-to-back throughput is one transaction per 3 + wait cycles.
- **Decode reject:** `done` arrives 1 cycle after the request is sampled.
- **Timeout:** strobes are high for exactly `TIMEOUT` cycles. `done` follows in the next cycle.

## Test plan
- **Single write:** `m0` writes addr 16'h2004, data 16'hBEEF; slave acks on the 1st BUSY cycle.
  - `s_we` is high for 1 cycle with `s_addr`=16'h2004 and `s_wdata`=16'hBEEF.
  - `m0_done` pulses 2 cycles after `req`, with `m0_err`=0.
- **Read with wait states:** `m1` reads 16'hC000; slave acks after 3 cycles with 16'h1234.
  - `s_re` is high for 3 cycles.
  - `m1_done` pulses with `m1_rdata`=16'h1234; `m0_done` stays 0 throughout.
- **Round-robin:** both masters hold `req` continuously for 4 transactions, with zero-wait acks.
  - Grant order is m0, m1, m0, m1.
  - Each `done` is 3 cycles apart.
- **Timeout:** `TIMEOUT`=15 and the slave never acks.
  - `s_re` is high for exactly 15 cycles.
  - `m0_done` pulses with `m0_err`=1 and `m0_rdata`=16'hFFFF.
  - A repeat of the test where `s_ack` arrives on the 15th cycle gives `m0_err`=0.
- **Decode reject:** `m0` reads 16'h1FFF.
  - No strobe is asserted.
  - `m0_done` and `m0_err` are high 1 cycle after the request is sampled, with `m0_rdata`=16'hFFFF.
- **Reset mid-operation:** assert `rst` asynchronously during BUSY.
  - All outputs go to 0 immediately, with no `done` pulse.
  - After release, a simultaneous m0/m1 request grants m0 first.
